// File: rtl/haz_gen2_pkg.sv
// Shared state encodings and stage-mask helpers for the second-generation
// hazard resolver.
package haz_gen2_pkg;

  typedef enum logic [2:0] {
    ST_NORMAL       = 3'd0,
    ST_CTRL_WAIT    = 3'd1,
    ST_DATA_STALL   = 3'd2,
    ST_STRUCT_STALL = 3'd3,
    ST_FLUSH        = 3'd4
  } haz_state_e;

  // Masks are built at full width and sliced down to NSTAGE by the user.
  localparam int MASK_W = 32;

  // Number of low stages held while waiting on a branch vs. a data/struct stall.
  localparam int CTRL_STALL_BITS = 1;
  localparam int HOLD_STALL_BITS = 2;

  function automatic logic [MASK_W-1:0] low_mask(input int n);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int i = 0; i < MASK_W; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/haz_resolver_gen2_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (ena) begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/haz_resolver_gen2.sv
// Pipeline hazard resolver FSM: turns decode hazard flags into PC freeze,
// per-stage stall/flush vectors and an EX bubble, with event counters.
module haz_resolver_gen2
  import haz_gen2_pkg::*;
#(
  parameter int NSTAGE         = 5,
  parameter int DATA_STALL_MAX = 3,
  parameter int LOAD_STALL     = 1,
  parameter int FLUSH_CYC      = 2,
  parameter int FLUSH_DEPTH    = 2,
  parameter int CNT_W          = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              raw_hz,
  input  logic [1:0]        raw_dist,
  input  logic              is_load,
  input  logic              fwd_ok,
  input  logic              str_hz,
  input  logic              br_pend,
  input  logic              br_resolve,
  input  logic              br_correct,
  input  logic              clr_cnt,
  output logic              pc_freeze,
  output logic [NSTAGE-1:0] stall_vec,
  output logic [NSTAGE-1:0] flush_vec,
  output logic              bubble,
  output logic              resolved,
  output logic [2:0]        state_o,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // The countdown holds "cycles remaining minus one" for whichever timed
  // state is longest, so size it from the largest load value.
  localparam int CD_MAX = max3(FLUSH_CYC, DATA_STALL_MAX, LOAD_STALL);
  localparam int CD_W   = (CD_MAX > 1) ? $clog2(CD_MAX) : 1;

  localparam logic [MASK_W-1:0] CTRL_MASK  = low_mask(CTRL_STALL_BITS);
  localparam logic [MASK_W-1:0] HOLD_MASK  = low_mask(HOLD_STALL_BITS);
  localparam logic [MASK_W-1:0] FLUSH_MASK = low_mask(FLUSH_DEPTH);
  localparam logic [CD_W-1:0]   FLUSH_LOAD = CD_W'(FLUSH_CYC - 1);

  haz_state_e      state_q, state_d;
  logic [CD_W-1:0] cd_q, cd_d;
  logic            resolved_q, resolved_d;

  logic            mispredict;
  logic            need_zero;
  logic [CD_W-1:0] need_cd;
  int              d_clamp;
  logic            flush_entry;

  assign mispredict = br_resolve & ~br_correct;

  // Stall length for a RAW hazard; a forwarded non-load needs no stall.
  always_comb begin
    d_clamp = int'(raw_dist);
    if (d_clamp < 1) d_clamp = 1;
    if (d_clamp > DATA_STALL_MAX) d_clamp = DATA_STALL_MAX;
    need_zero = 1'b0;
    need_cd   = '0;
    if (is_load && fwd_ok) begin
      need_cd = CD_W'(LOAD_STALL - 1);
    end else if (fwd_ok) begin
      need_zero = 1'b1;
    end else begin
      need_cd = CD_W'(DATA_STALL_MAX - d_clamp);
    end
  end

  // NOTE: every always_comb output gets a default first so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    case (state_q)
      ST_NORMAL: begin
        if (mispredict) begin
          state_d = ST_FLUSH;
          cd_d    = FLUSH_LOAD;
        end else if (str_hz) begin
          state_d = ST_STRUCT_STALL;
        end else if (raw_hz && !need_zero) begin
          state_d = ST_DATA_STALL;
          cd_d    = need_cd;
        end else if (br_pend) begin
          state_d = ST_CTRL_WAIT;
        end
      end
      ST_CTRL_WAIT: begin
        if (br_resolve) begin
          if (br_correct) begin
            state_d = ST_NORMAL;
          end else begin
            state_d = ST_FLUSH;
            cd_d    = FLUSH_LOAD;
          end
        end
      end
      ST_DATA_STALL: begin
        if (mispredict) begin
          state_d = ST_FLUSH;
          cd_d    = FLUSH_LOAD;
        end else if (cd_q == '0) begin
          state_d = ST_NORMAL;
        end else begin
          cd_d = cd_q - CD_W'(1);
        end
      end
      ST_STRUCT_STALL: begin
        if (mispredict) begin
          state_d = ST_FLUSH;
          cd_d    = FLUSH_LOAD;
        end else if (!str_hz) begin
          state_d = ST_NORMAL;
        end
      end
      ST_FLUSH: begin
        // Fetch is being redirected; a late branch resolution is moot here.
        if (cd_q == '0) begin
          state_d = ST_NORMAL;
        end else begin
          cd_d = cd_q - CD_W'(1);
        end
      end
      default: begin
        state_d = ST_NORMAL;
        cd_d    = '0;
      end
    endcase
  end

  assign resolved_d  = ena && (state_d == ST_NORMAL) && (state_q != ST_NORMAL);
  assign flush_entry = (state_d == ST_FLUSH) && (state_q != ST_FLUSH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_NORMAL;
      cd_q       <= '0;
      resolved_q <= 1'b0;
    end else begin
      if (ena) begin
        state_q <= state_d;
        cd_q    <= cd_d;
      end
      resolved_q <= resolved_d;
    end
  end

  // Moore decode from the registered state only.
  always_comb begin
    pc_freeze = 1'b0;
    stall_vec = '0;
    flush_vec = '0;
    bubble    = 1'b0;
    case (state_q)
      ST_CTRL_WAIT: begin
        pc_freeze = 1'b1;
        stall_vec = CTRL_MASK[NSTAGE-1:0];
      end
      ST_DATA_STALL, ST_STRUCT_STALL: begin
        pc_freeze = 1'b1;
        stall_vec = HOLD_MASK[NSTAGE-1:0];
        bubble    = 1'b1;
      end
      ST_FLUSH: begin
        flush_vec = FLUSH_MASK[NSTAGE-1:0];
      end
      default: begin
        pc_freeze = 1'b0;
      end
    endcase
  end

  assign resolved = resolved_q;
  assign state_o  = state_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .inc   (pc_freeze),
    .clr   (clr_cnt),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .inc   (flush_entry),
    .clr   (clr_cnt),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_haz_resolver_gen2.sv
// Scoreboard bench for haz_resolver_gen2: directed scenarios plus random
// traffic, predicted by a cycle-count reference model.
module tb_haz_resolver_gen2;

  localparam int NSTAGE         = 5;
  localparam int DATA_STALL_MAX = 3;
  localparam int LOAD_STALL     = 1;
  localparam int FLUSH_CYC      = 2;
  localparam int FLUSH_DEPTH    = 2;

  typedef struct packed {
    logic       ena;
    logic       raw_hz;
    logic [1:0] raw_dist;
    logic       is_load;
    logic       fwd_ok;
    logic       str_hz;
    logic       br_pend;
    logic       br_resolve;
    logic       br_correct;
    logic       clr_cnt;
  } in_t;

  typedef struct packed {
    logic       pc_freeze;
    logic [4:0] stall_vec;
    logic [4:0] flush_vec;
    logic       bubble;
    logic       resolved;
    logic [2:0] state;
    logic [7:0] stall_cnt;
    logic [7:0] flush_cnt;
    logic [1:0] stall_cnt2;
    logic [1:0] flush_cnt2;
  } out_t;

  typedef enum {M_IDLE, M_CTRL, M_DATA, M_STRUCT, M_FLUSH} mode_e;

  logic clk = 1'b0;
  logic rst_n;
  logic ena, raw_hz, is_load, fwd_ok, str_hz, br_pend, br_resolve, br_correct, clr_cnt;
  logic [1:0] raw_dist;

  logic              pc_freeze, bubble, resolved;
  logic [NSTAGE-1:0] stall_vec, flush_vec;
  logic [2:0]        state_o;
  logic [7:0]        stall_cnt, flush_cnt;

  logic              pc_freeze2, bubble2, resolved2;
  logic [NSTAGE-1:0] stall_vec2, flush_vec2;
  logic [2:0]        state_o2;
  logic [1:0]        stall_cnt2, flush_cnt2;

  always #5 clk = ~clk;

  haz_resolver_gen2 #(
    .NSTAGE(NSTAGE), .DATA_STALL_MAX(DATA_STALL_MAX), .LOAD_STALL(LOAD_STALL),
    .FLUSH_CYC(FLUSH_CYC), .FLUSH_DEPTH(FLUSH_DEPTH), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .raw_hz(raw_hz), .raw_dist(raw_dist),
    .is_load(is_load), .fwd_ok(fwd_ok), .str_hz(str_hz), .br_pend(br_pend),
    .br_resolve(br_resolve), .br_correct(br_correct), .clr_cnt(clr_cnt),
    .pc_freeze(pc_freeze), .stall_vec(stall_vec), .flush_vec(flush_vec),
    .bubble(bubble), .resolved(resolved), .state_o(state_o),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  haz_resolver_gen2 #(
    .NSTAGE(NSTAGE), .DATA_STALL_MAX(DATA_STALL_MAX), .LOAD_STALL(LOAD_STALL),
    .FLUSH_CYC(FLUSH_CYC), .FLUSH_DEPTH(FLUSH_DEPTH), .CNT_W(2)
  ) dut_narrow (
    .clk(clk), .rst_n(rst_n), .ena(ena), .raw_hz(raw_hz), .raw_dist(raw_dist),
    .is_load(is_load), .fwd_ok(fwd_ok), .str_hz(str_hz), .br_pend(br_pend),
    .br_resolve(br_resolve), .br_correct(br_correct), .clr_cnt(clr_cnt),
    .pc_freeze(pc_freeze2), .stall_vec(stall_vec2), .flush_vec(flush_vec2),
    .bubble(bubble2), .resolved(resolved2), .state_o(state_o2),
    .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
  );

  out_t obs, obs2;
  assign obs  = {pc_freeze, stall_vec, flush_vec, bubble, resolved, state_o,
                 stall_cnt, flush_cnt, stall_cnt2, flush_cnt2};
  assign obs2 = {pc_freeze2, stall_vec2, flush_vec2, bubble2, resolved2, state_o2,
                 8'h00, 8'h00, stall_cnt2, flush_cnt2};

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc_no = 0;
  out_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  mode_e m_mode;
  int    m_remain;
  int    m_stall, m_flush, m_stall2, m_flush2;
  bit    m_resolved;

  function automatic int sat_inc(input int v, input int w);
    return (v < (1 << w) - 1) ? v + 1 : v;
  endfunction

  function automatic int need_of(input in_t x);
    int d;
    if (x.is_load && x.fwd_ok) return LOAD_STALL;
    if (x.fwd_ok) return 0;
    d = int'(x.raw_dist);
    if (d < 1) d = 1;
    if (d > DATA_STALL_MAX) d = DATA_STALL_MAX;
    return DATA_STALL_MAX + 1 - d;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_remain = 0; m_resolved = 0;
    m_stall = 0; m_flush = 0; m_stall2 = 0; m_flush2 = 0;
  endtask

  task automatic model_step(input in_t x);
    mode_e prev;
    bit    mis, froze;
    if (!x.ena) begin
      m_resolved = 0;
      return;
    end
    prev  = m_mode;
    froze = (m_mode == M_CTRL) || (m_mode == M_DATA) || (m_mode == M_STRUCT);
    mis   = x.br_resolve && !x.br_correct;
    case (m_mode)
      M_IDLE: begin
        if (mis) begin m_mode = M_FLUSH; m_remain = FLUSH_CYC; end
        else if (x.str_hz) m_mode = M_STRUCT;
        else if (x.raw_hz && need_of(x) > 0) begin m_mode = M_DATA; m_remain = need_of(x); end
        else if (x.br_pend) m_mode = M_CTRL;
      end
      M_CTRL: if (x.br_resolve) begin
        if (x.br_correct) m_mode = M_IDLE;
        else begin m_mode = M_FLUSH; m_remain = FLUSH_CYC; end
      end
      M_DATA: begin
        if (mis) begin m_mode = M_FLUSH; m_remain = FLUSH_CYC; end
        else begin m_remain--; if (m_remain == 0) m_mode = M_IDLE; end
      end
      M_STRUCT: begin
        if (mis) begin m_mode = M_FLUSH; m_remain = FLUSH_CYC; end
        else if (!x.str_hz) m_mode = M_IDLE;
      end
      M_FLUSH: begin
        m_remain--; if (m_remain == 0) m_mode = M_IDLE;
      end
      default: m_mode = M_IDLE;
    endcase
    if (x.clr_cnt) begin
      m_stall = 0; m_flush = 0; m_stall2 = 0; m_flush2 = 0;
    end else begin
      if (froze) begin m_stall = sat_inc(m_stall, 8); m_stall2 = sat_inc(m_stall2, 2); end
      if (m_mode == M_FLUSH && prev != M_FLUSH) begin
        m_flush = sat_inc(m_flush, 8); m_flush2 = sat_inc(m_flush2, 2);
      end
    end
    m_resolved = (m_mode == M_IDLE) && (prev != M_IDLE);
  endtask

  function automatic out_t model_out();
    out_t o;
    o = '0;
    case (m_mode)
      M_CTRL:   begin o.pc_freeze = 1; o.stall_vec = 5'b00001; o.state = 3'd1; end
      M_DATA:   begin o.pc_freeze = 1; o.stall_vec = 5'b00011; o.bubble = 1; o.state = 3'd2; end
      M_STRUCT: begin o.pc_freeze = 1; o.stall_vec = 5'b00011; o.bubble = 1; o.state = 3'd3; end
      M_FLUSH:  begin o.flush_vec = 5'((1 << FLUSH_DEPTH) - 1); o.state = 3'd4; end
      default:  o.state = 3'd0;
    endcase
    o.resolved   = m_resolved;
    o.stall_cnt  = 8'(m_stall);
    o.flush_cnt  = 8'(m_flush);
    o.stall_cnt2 = 2'(m_stall2);
    o.flush_cnt2 = 2'(m_flush2);
    return o;
  endfunction

  // ---------------- monitor ----------------
  always begin
    out_t e, e2;
    @(posedge clk or negedge rst_n);
    #1;
    cyc_no++;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      e2 = e;
      e2.stall_cnt = 8'h00;
      e2.flush_cnt = 8'h00;
      check($sformatf("cyc%0d_main", cyc_no), 64'(obs), 64'(e));
      check($sformatf("cyc%0d_narrow", cyc_no), 64'(obs2), 64'(e2));
    end
  end

  // ---------------- driver ----------------
  task automatic apply(input in_t x);
    ena = x.ena; raw_hz = x.raw_hz; raw_dist = x.raw_dist; is_load = x.is_load;
    fwd_ok = x.fwd_ok; str_hz = x.str_hz; br_pend = x.br_pend;
    br_resolve = x.br_resolve; br_correct = x.br_correct; clr_cnt = x.clr_cnt;
  endtask

  function automatic in_t idle();
    in_t x;
    x = '0;
    x.ena = 1'b1;
    return x;
  endfunction

  task automatic cyc(input in_t x);
    @(negedge clk);
    rst_n = 1'b1;
    apply(x);
    model_step(x);
    exp_q.push_back(model_out());
  endtask

  task automatic idles(input int n);
    for (int i = 0; i < n; i++) cyc(idle());
  endtask

  task automatic hold_reset();
    @(negedge clk);
    rst_n = 1'b0;
    apply(idle());
    model_reset();
    exp_q.push_back(model_out());
  endtask

  // Drop reset between clock edges; the monitor samples 1 time unit later.
  task automatic async_reset();
    @(posedge clk);
    #3;
    model_reset();
    exp_q.push_back(model_out());
    rst_n = 1'b0;
  endtask

  function automatic in_t rand_in();
    in_t x;
    x.ena        = ($urandom_range(0, 99) < 90);
    x.raw_hz     = ($urandom_range(0, 99) < 35);
    x.raw_dist   = 2'($urandom_range(0, 3));
    x.is_load    = ($urandom_range(0, 99) < 50);
    x.fwd_ok     = ($urandom_range(0, 99) < 50);
    x.str_hz     = ($urandom_range(0, 99) < 12);
    x.br_pend    = ($urandom_range(0, 99) < 15);
    x.br_resolve = ($urandom_range(0, 99) < 20);
    x.br_correct = ($urandom_range(0, 99) < 60);
    x.clr_cnt    = ($urandom_range(0, 99) < 3);
    return x;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    in_t x;
    int  waited;
    rst_n = 1'b0;
    apply(idle());
    model_reset();
    hold_reset();
    hold_reset();
    idles(3);

    x = idle(); x.raw_hz = 1; x.raw_dist = 2'd1; cyc(x); idles(5);
    x = idle(); x.raw_hz = 1; x.is_load = 1; x.fwd_ok = 1; cyc(x); idles(3);
    x = idle(); x.raw_hz = 1; x.fwd_ok = 1; cyc(x); idles(2);
    x = idle(); x.raw_hz = 1; x.raw_dist = 2'd3; cyc(x); idles(3);
    x = idle(); x.raw_hz = 1; x.raw_dist = 2'd0; cyc(x); idles(4);

    x = idle(); x.br_pend = 1;
    repeat (4) cyc(x);
    x.br_resolve = 1; x.br_correct = 1; cyc(x); idles(2);
    x = idle(); x.br_pend = 1;
    repeat (4) cyc(x);
    x.br_resolve = 1; x.br_correct = 0; cyc(x); idles(4);

    x = idle(); x.str_hz = 1; x.raw_hz = 1; x.raw_dist = 2'd1; x.br_pend = 1;
    repeat (3) cyc(x);
    idles(2);

    x = idle(); x.raw_hz = 1; x.raw_dist = 2'd1; cyc(x); idles(1);
    x = idle(); x.br_resolve = 1; x.br_correct = 0; cyc(x); idles(4);

    x = idle(); x.raw_hz = 1; x.raw_dist = 2'd1; cyc(x); idles(1);
    x = idle(); x.ena = 0; repeat (3) cyc(x);
    idles(4);

    x = idle(); x.raw_hz = 1; x.raw_dist = 2'd1; cyc(x); idles(1);
    x = idle(); x.clr_cnt = 1; cyc(x); idles(3);

    x = idle(); x.br_resolve = 1; x.br_correct = 0; cyc(x);
    async_reset();
    idles(3);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) async_reset();
      else cyc(rand_in());
    end
    idles(4);

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #2;
    check("scoreboard_drain", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
